// File: rtl/hist_ctrl_pkg.sv
// Shared state encoding, default parameters and helpers for the histogram run controller.
package hist_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } run_state_e;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_NUM_BINS      = 256;
    localparam int DEF_CNT_WIDTH     = 16;
    localparam int DEF_FLUSH_TIMEOUT = 64;

    // Address width for a bin index; a single-bin histogram still needs one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hist_clr_seq.sv
// Bin-clear address generator: walks clr_addr upward while go is high, restarts at 0 on done.
module hist_clr_seq
    import hist_ctrl_pkg::*;
#(
    parameter int NUM_BINS = DEF_NUM_BINS
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          go,
    input  logic                          done,
    output logic [addr_w(NUM_BINS)-1:0]   clr_addr,
    output logic                          clr_en
);

    localparam int AW = addr_w(NUM_BINS);

    logic [AW-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = '0;
        if (go && !done) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign clr_addr = addr_q;
    assign clr_en   = go;

endmodule

// File: rtl/hist_run_ctrl.sv
// Histogram run controller: clear bins, pass num_samples stream beats, wait for flush, pulse done.
// Optional flush watchdog enabled by defining HIST_RUN_CTRL_FLUSH_TIMEOUT_EN.
module hist_run_ctrl
    import hist_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_BINS      = DEF_NUM_BINS,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CNT_WIDTH-1:0]          num_samples,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [addr_w(NUM_BINS)-1:0]   clr_addr,
    output logic                          clr_en,
    input  logic                          hist_busy,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_WIDTH-1:0]          sample_cnt,
    output logic                          timeout_err
);

    localparam int AW = addr_w(NUM_BINS);

    run_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] tgt_q, tgt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 run_pass;
    logic                 s_hs;
    logic                 clr_go;
    logic                 clr_last;

`ifdef HIST_RUN_CTRL_FLUSH_TIMEOUT_EN
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    // Abort gates the stream in its own cycle so a beat is never passed but left uncounted.
    assign run_pass      = (state_q == ST_RUN) && !abort;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = run_pass && s_axis_tvalid;
    assign s_axis_tready = run_pass && m_axis_tready;
    assign s_hs          = run_pass && s_axis_tvalid && m_axis_tready;

    assign clr_go   = (state_q == ST_CLEAR);
    assign clr_last = clr_go && (clr_addr == AW'(NUM_BINS - 1));
    assign cnt_inc  = cnt_q + 1'b1;

    hist_clr_seq #(
        .NUM_BINS (NUM_BINS)
    ) u_clr_seq (
        .aclk     (aclk),
        .areset   (areset),
        .go       (clr_go),
        .done     (clr_last || abort),
        .clr_addr (clr_addr),
        .clr_en   (clr_en)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
`ifdef HIST_RUN_CTRL_FLUSH_TIMEOUT_EN
        tmo_d   = '0;
        err_d   = err_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tgt_d   = num_samples;
                        cnt_d   = '0;
`ifdef HIST_RUN_CTRL_FLUSH_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                        state_d = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_last) begin
                        state_d = (tgt_q == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // cnt_q < tgt_q holds throughout RUN, so the increment cannot wrap.
                    if (s_hs) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == tgt_q) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!hist_busy) begin
                        state_d = ST_DONE;
                    end
`ifdef HIST_RUN_CTRL_FLUSH_TIMEOUT_EN
                    else if (tmo_q == TW'(FLUSH_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef HIST_RUN_CTRL_FLUSH_TIMEOUT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign sample_cnt = cnt_q;

endmodule

// File: doc/hist_run_ctrl.md
HIST_RUN_CTRL -- requirements
Module: hist_run_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 32, AXI-Stream data width.
- NUM_BINS, 256, number of histogram bins to clear.
- CNT_WIDTH, 16, sample counter width.
- FLUSH_TIMEOUT, 64, flush wait limit in cycles.
REQ-002 Ports SHALL be:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset, asynchronous, active-high.
- start  in  1  run request, sampled in IDLE only.
- abort  in  1  run cancel, valid in any state.
- num_samples  in  CNT_WIDTH  samples per run, latched on accepted start.
- s_axis_tdata/tvalid/tready  in/in/out  DATA_WIDTH/1/1  stream from LFSR.
- m_axis_tdata/tvalid/tready  out/out/in  DATA_WIDTH/1/1  stream to histogram.
- clr_addr  out  log2(NUM_BINS)  bin address being zeroed.
- clr_en  out  1  bin clear write strobe.
- hist_busy  in  1  histogram has updates in flight.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run completion.
- sample_cnt  out  CNT_WIDTH  samples accepted in the current run.
- timeout_err  out  1  sticky flush-timeout flag (macro-gated, see REQ-016).

Function
REQ-003 The FSM SHALL have the states IDLE, CLEAR, RUN, FLUSH and DONE.
REQ-004 In IDLE, start=1 SHALL latch num_samples, zero sample_cnt, clear timeout_err and enter CLEAR on the next edge; start in any other state SHALL be ignored.
REQ-005 CLEAR SHALL assert clr_en for exactly NUM_BINS consecutive cycles with clr_addr = 0,1,…,NUM_BINS-1, then go to RUN; if the latched count is 0, it SHALL go to DONE instead.
REQ-006 In RUN the stream SHALL pass combinationally, with m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid and s_axis_tready=m_axis_tready; outside RUN, m_axis_tvalid=0 and s_axis_tready=0.
REQ-007 sample_cnt SHALL increment on each s_axis handshake in RUN, and the handshake that makes sample_cnt equal the latched count SHALL move the FSM to FLUSH, so exactly num_samples beats pass.
REQ-008 FLUSH SHALL wait until hist_busy=0, sampled no earlier than the cycle after entry, then go to DONE.
REQ-009 DONE SHALL last one cycle with done=1, then return to IDLE; sample_cnt SHALL hold its final value until the next accepted start.
REQ-010 abort=1 in any state SHALL force IDLE on the next edge, with clr_en=0 and the stream gated; done SHALL not pulse, and abort SHALL take priority over start and all transitions in the same cycle.
REQ-011 sample_cnt SHALL never wrap; a latched count of 2^CNT_WIDTH-1 SHALL be a legal run.
REQ-012 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-013 While areset=1, the block SHALL be in IDLE with sample_cnt=0, clr_addr=0, clr_en=0, done=0, busy=0, timeout_err=0, m_axis_tvalid=0 and s_axis_tready=0.
REQ-014 An areset asserted mid-run SHALL take effect immediately, with no completion of the clear or stream; release SHALL be followed by IDLE.

Configuration
REQ-015 Macro HIST_RUN_CTRL_FLUSH_TIMEOUT_EN SHALL gate the flush watchdog.
REQ-016 When the macro is defined, a cycle counter SHALL run in FLUSH; after FLUSH_TIMEOUT cycles with hist_busy=1, timeout_err SHALL set (sticky until next start or reset) and the FSM SHALL go to DONE. When the macro is undefined, FLUSH SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-017 The FSM state enumeration and the default parameter constants SHALL reside in shared package hist_ctrl_pkg.
REQ-018 The bin-clear address generator SHALL be sub-module hist_clr_seq, with inputs go and done and outputs clr_addr and clr_en; all other logic SHALL stay flat.

Verification
REQ-019 A bench SHALL cover these directed scenarios:
- Reset, then start with num_samples=10, m_axis_tready=1, LFSR always valid: clr_en is high for 256 cycles (addr 0..255), exactly 10 m_axis beats follow, done pulses once, sample_cnt=10.
- num_samples=0: after the 256 clear cycles, done follows with no m_axis beat.
- num_samples=5 with m_axis_tready toggling every cycle: exactly 5 beats pass, data matches s_axis_tdata, and no beat is accepted while tready=0.
- abort at sample 3 of 8: IDLE next cycle, no done pulse, s_axis_tready=0; a following start runs a clean full run.
- hist_busy held high in FLUSH for 100 cycles: with the macro, timeout_err=1 and done after 64 cycles; without the macro, done occurs 1 cycle after hist_busy falls.
- areset pulsed during CLEAR (addr=40): all outputs reach their reset values immediately; start is ignored while busy.
